// File: rtl/fica_mul4_if.sv
// Sample-stream, accumulator and weight-update handshake bundle
// for the FastICA 4x4-block multiply sequencer.
// Ports: s_valid/s_ready/s_addr sample fetch, en_mul multiplier
//        enable, acc_clr/acc_en accumulator control,
//        upd_start/upd_done/conv weight-update handshake.
// master = controller side, slave = datapath/memory side.
interface fica_mul4_if #(
    parameter int ADDR_W = 10
);
    logic              s_valid;
    logic              s_ready;
    logic [ADDR_W-1:0] s_addr;
    logic              en_mul;
    logic              acc_clr;
    logic              acc_en;
    logic              upd_start;
    logic              upd_done;
    logic              conv;

    modport master (
        input  s_valid, upd_done, conv,
        output s_ready, s_addr, en_mul,
        output acc_clr, acc_en, upd_start
    );

    modport slave (
        output s_valid, upd_done, conv,
        input  s_ready, s_addr, en_mul,
        input  acc_clr, acc_en, upd_start
    );
endinterface

// File: rtl/fica_mul4_ctrl.sv
// FastICA iteration sequencer: streams samples into the 4x4-block
// multiplier, aligns accumulator enables with the multiplier's
// register stage, and runs weight-update passes until convergence.
// Ports: clk_ctrl, rst_ctrl (sync, active high), start, bus
//        (fica_mul4_if.master), busy, done, converged, iter_cnt,
//        timeout.
// Optional macro FICA_CTRL_TIMEOUT_EN enables the update watchdog;
// without it the update wait is unbounded and timeout is 0.
module fica_mul4_ctrl #(
    parameter int N_SAMPLES = 1024,
    parameter int ADDR_W    = 10,
    parameter int MAX_ITER  = 64,
    parameter int ITER_W    = 7,
    parameter int TO_CYCLES = 256
) (
    input  logic              clk_ctrl,
    input  logic              rst_ctrl,
    input  logic              start,
    fica_mul4_if.master       bus,
    output logic              busy,
    output logic              done,
    output logic              converged,
    output logic [ITER_W-1:0] iter_cnt,
    output logic              timeout
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_UPDATE,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [ADDR_W-1:0] addr_q;
    logic              acc_en_q;
    logic              first_q;
    logic [ITER_W-1:0] iter_q;
    logic              conv_q;
    logic              accept;
    logic              last;
    logic              upd_hit;
    logic              end_run;
    logic              to_hit;

    assign accept  = (state == S_STREAM) && bus.s_valid;
    assign last    = (addr_q == ADDR_W'(N_SAMPLES - 1));
    assign upd_hit = (state == S_UPDATE) && bus.upd_done;
    assign end_run = upd_hit &&
                     (bus.conv || (iter_q == ITER_W'(MAX_ITER - 1)));

    assign bus.s_ready   = (state == S_STREAM);
    assign bus.en_mul    = bus.s_valid && bus.s_ready;
    assign bus.s_addr    = addr_q;
    assign bus.acc_clr   = (state == S_CLEAR);
    // acc_en trails the accept by one cycle, matching the multiplier
    // output register; the last one lands in DRAIN.
    assign bus.acc_en    = acc_en_q;
    assign bus.upd_start = (state == S_UPDATE) && first_q;
    assign busy          = (state != S_IDLE);
    assign done          = (state == S_DONE);
    assign converged     = conv_q;
    assign iter_cnt      = iter_q;

`ifdef FICA_CTRL_TIMEOUT_EN
    localparam int TO_W = $clog2(TO_CYCLES + 1);
    logic [TO_W-1:0] to_q;
    logic            to_flag;

    // upd_done on the limit cycle takes priority over the watchdog.
    assign to_hit  = (state == S_UPDATE) && !bus.upd_done &&
                     (to_q == TO_W'(TO_CYCLES - 1));
    assign timeout = to_flag;

    always_ff @(posedge clk_ctrl) begin
        if (rst_ctrl) begin
            to_q    <= '0;
            to_flag <= 1'b0;
        end else begin
            if (state == S_UPDATE) to_q <= to_q + 1'b1;
            else                   to_q <= '0;
            if ((state == S_IDLE) && start) to_flag <= 1'b0;
            else if (to_hit)                to_flag <= 1'b1;
        end
    end
`else
    assign to_hit  = 1'b0;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:   if (start) state_n = S_CLEAR;
            S_CLEAR:  state_n = S_STREAM;
            S_STREAM: if (accept && last) state_n = S_DRAIN;
            S_DRAIN:  state_n = S_UPDATE;
            S_UPDATE: begin
                if (end_run || to_hit) state_n = S_DONE;
                else if (upd_hit)      state_n = S_CLEAR;
            end
            S_DONE:   state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_ctrl) begin
        if (rst_ctrl) begin
            state    <= S_IDLE;
            addr_q   <= '0;
            acc_en_q <= 1'b0;
            first_q  <= 1'b0;
            iter_q   <= '0;
            conv_q   <= 1'b0;
        end else begin
            state    <= state_n;
            acc_en_q <= accept;
            first_q  <= (state == S_DRAIN);
            if (state_n == S_CLEAR)
                addr_q <= '0;
            else if (accept && !last)
                addr_q <= addr_q + 1'b1;
            if ((state == S_IDLE) && start) begin
                iter_q <= '0;
                conv_q <= 1'b0;
            end else if (upd_hit) begin
                iter_q <= iter_q + 1'b1;
                if (end_run) conv_q <= bus.conv;
            end else if (to_hit) begin
                conv_q <= 1'b0;
            end
        end
    end
endmodule

// File: doc/fica_mul4_ctrl.md
Name: fica_mul4_ctrl

Overview:
- Sequencer for one FastICA iteration pass over the 4x4-block multiply datapath (z times (z^T w)^3 products).
- Streams N_SAMPLES whitened samples from sample memory into the multiplier and drives its en_mul.
- Aligns accumulator enable/clear with the multiplier's one-cycle register latency, then hands off to the weight-update unit.
- Repeats passes until the update unit reports convergence or MAX_ITER passes complete.

Parameters:
N_SAMPLES, 1024, samples per pass (>=2)
ADDR_W, 10, sample address width; 2^ADDR_W >= N_SAMPLES
MAX_ITER, 64, maximum passes per run (>=1)
ITER_W, 7, iteration counter width; must hold MAX_ITER
TO_CYCLES, 256, update-wait watchdog limit (optional feature only)

Ports:
clk_ctrl  in  1  clock; all logic on rising edge
rst_ctrl  in  1  synchronous active-high reset
start  in  1  run request pulse; honoured only in IDLE
s_valid  in  1  sample at s_addr present on z bus
s_ready  out  1  controller accepts sample this cycle
s_addr  out  ADDR_W  sample memory address
en_mul  out  1  multiplier enable (combinational: s_valid & s_ready)
acc_clr  out  1  accumulator clear, one cycle
acc_en  out  1  accumulator capture of multiplier output
upd_start  out  1  weight-update request pulse
upd_done  in  1  weight-update complete pulse
conv  in  1  convergence flag, sampled only with upd_done
busy  out  1  high in every state except IDLE
done  out  1  run-complete pulse, one cycle
converged  out  1  result of last run, held until next start
iter_cnt  out  ITER_W  completed passes in current/last run
timeout  out  1  watchdog fired; tied 0 without macro

Behaviour:
- Reset: state IDLE; s_ready, en_mul, acc_clr, acc_en, upd_start, busy, done, converged, timeout = 0; s_addr = 0; iter_cnt = 0. Reset mid-run aborts immediately, no done pulse.
- States: IDLE, CLEAR, STREAM, DRAIN, UPDATE, DONE.
- IDLE: start -> CLEAR; iter_cnt, converged, timeout cleared on same edge. start in any other state ignored.
- CLEAR (1 cycle): acc_clr=1, s_addr=0 -> STREAM.
- STREAM: s_ready=1. Accept = s_valid & s_ready; en_mul=accept (same cycle, so the multiplier captures z with the accept edge). On accept, s_addr+1; accept at s_addr=N_SAMPLES-1 -> DRAIN with s_addr held. s_valid low stalls; s_addr holds, no en_mul.
- acc_en = accept registered one cycle (matches multiplier output register); exactly N_SAMPLES acc_en pulses per pass, none while acc_clr high.
- DRAIN (1 cycle): final acc_en asserted here -> UPDATE.
- UPDATE: upd_start=1 on first cycle only; wait for upd_done. On upd_done: iter_cnt+1; if conv=1 or iter_cnt+1==MAX_ITER -> DONE with converged=conv; else -> CLEAR. upd_done in other states ignored. upd_done in first UPDATE cycle (same cycle as upd_start) is legal and accepted.
- DONE (1 cycle): done=1 -> IDLE. busy low from IDLE onward.
- Sample throughput: one per cycle with s_valid held high; pass length = N_SAMPLES+3 cycles plus update wait.

Optional Feature:
FICA_CTRL_TIMEOUT_EN
- Defined: cycle counter runs in UPDATE; if TO_CYCLES cycles pass without upd_done -> DONE with timeout=1, converged=0, iter_cnt unchanged; timeout held until next start. upd_done on the same cycle the limit is reached wins (normal completion).
- Undefined: no counter; UPDATE waits indefinitely; timeout port tied 0.

Test Plan:
- N_SAMPLES=4, MAX_ITER=3, s_valid always 1, upd_done 2 cycles after upd_start with conv=1 -> s_addr 0,1,2,3; 4 en_mul, 4 acc_en each 1 cycle later; done once; converged=1, iter_cnt=1.
- Same, conv=0 always -> 3 passes, acc_clr before each pass, done after 3rd upd_done; converged=0, iter_cnt=3.
- s_valid toggling 1,0,1,0 -> s_addr advances only on accepts; en_mul never high with s_valid=0; acc_en count still 4 per pass.
- start pulsed during STREAM -> ignored; rst_ctrl asserted mid-STREAM -> next cycle all outputs 0, state IDLE, no done.
- upd_done concurrent with upd_start (conv=1) -> accepted; DONE next cycle.
- With FICA_CTRL_TIMEOUT_EN, TO_CYCLES=8, upd_done never -> done 8 cycles after UPDATE entry, timeout=1, converged=0; without macro, busy stays 1.
